keypad_hex_entry: RTL and testbench

4x4 matrix-keypad reader that turns key presses into hex digits. It is the input-side counterpart of the 4-digit seven-segment display path: it drives keypad rows, senses columns, debounces, and decodes each press to a 4-bit code. Codes shift into a 16-bit entry register whose output feeds the display's 16-bit hex input directly.

---
 rtl/keypad_hex_entry.sv | 199 +++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_hex_entry
// Function : 4x4 matrix keypad scanner with debounce. Each accepted press is
//            decoded to a hex digit and shifted into a 16-bit entry register.
// Revision : 1.0  initial release
// ============================================================================
module keypad_hex_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic        clk,
  input  logic        RST,
  output logic [3:0]  KROW,
  input  logic [3:0]  KCOL,
  input  logic        clr,
  output logic [15:0] HEXS,
  output logic [2:0]  ndigits,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_col_m;
  logic [3:0]       r_col_s;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_row_adv;
  logic             w_latch;
  logic             w_accept;
  logic             w_release_done;
  logic             w_sel_high;
  logic [1:0]       w_low_col;
  logic [1:0]       w_row_nxt;
  logic [3:0]       w_code;

  // Lowest-index low column wins when several keys share the scanned row
  assign w_low_col  = !r_col_s[0] ? 2'd0 :
                      !r_col_s[1] ? 2'd1 :
                      !r_col_s[2] ? 2'd2 : 2'd3;
  assign w_sel_high = r_col_s[r_col];
  assign w_row_nxt  = r_row + 2'd1;
  assign w_code     = {r_row, r_col};

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_col_m <= 4'hF;
      r_col_s <= 4'hF;
    end else begin
      r_col_m <= KCOL;
      r_col_s <= r_col_m;
    end
  end

  // State register plus the scan divider and debounce counter
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= S_SCAN;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: scan rows, then debounce press, hold, debounce release
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_cnt_nxt      = r_cnt;
    w_row_adv      = 1'b0;
    w_latch        = 1'b0;
    w_accept       = 1'b0;
    w_release_done = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (r_div == c_div_last) begin
          w_div_nxt = '0;
          if (r_col_s != 4'hF) begin
            w_latch     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DEBOUNCE;
          end else begin
            w_row_adv = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (w_sel_high) begin
          // A bounce abandons this key; scanning resumes on the next row
          w_cnt_nxt   = '0;
          w_row_adv   = 1'b1;
          w_state_nxt = S_SCAN;
        end else if (r_cnt == c_deb_last) begin
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
          w_state_nxt = S_HELD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (w_sel_high) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!w_sel_high) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HELD;
        end else if (r_cnt == c_deb_last) begin
          w_cnt_nxt      = '0;
          w_row_adv      = 1'b1;
          w_release_done = 1'b1;
          w_state_nxt    = S_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_SCAN;
    endcase
  end

  // Row drive and latched key position; the row is frozen outside SCAN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_row <= 2'd0;
      r_col <= 2'd0;
      KROW  <= 4'b1110;
    end else begin
      if (w_row_adv) begin
        r_row <= w_row_nxt;
        KROW  <= ~(4'b0001 << w_row_nxt);
      end
      if (w_latch) begin
        r_col <= w_low_col;
      end
    end
  end

  // Entry register, digit count and key status outputs
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      HEXS      <= 16'h0000;
      ndigits   <= 3'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= w_accept;
      if (w_accept) begin
        key_code <= w_code;
        if (clr) begin
          HEXS    <= {12'h000, w_code};
          ndigits <= 3'd1;
        end else begin
          HEXS <= {HEXS[11:0], w_code};
          if (ndigits != 3'd4) begin
            ndigits <= ndigits + 3'd1;
          end
        end
      end else if (clr) begin
        HEXS    <= 16'h0000;
        ndigits <= 3'd0;
      end
      if (w_accept) begin
        key_down <= 1'b1;
      end else if (w_release_done) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_hex_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_hex_entry
// Function : Directed self-checking bench for keypad_hex_entry with a
//            behavioural 4x4 key matrix.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_hex_entry;

  logic        clk;
  logic        rst_n;
  logic [3:0]  krow;
  logic [3:0]  kcol;
  logic        clr;
  logic [15:0] hexs;
  logic [2:0]  ndigits;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed;
  int          n_checks;
  int          n_fail;
  logic [3:0]  rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .RST       (rst_n),
    .KROW      (krow),
    .KCOL      (kcol),
    .clr       (clr),
    .HEXS      (hexs),
    .ndigits   (ndigits),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    kcol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!krow[r])
        for (int c = 0; c < 4; c++)
          if (pressed[4*r+c]) kcol[c] = 1'b0;
  end

  // Wait for the first cycle in which row pattern pat is driven
  task automatic wait_row_start(input logic [3:0] pat, output bit ok);
    int n;
    n = 0;
    while (krow === pat && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (krow !== pat && n < 40) begin @(negedge clk); n++; end
    ok = (krow === pat);
  endtask

  // Press one key, hold, release; report key_valid pulses and release completion
  task automatic press_key(input int code, output int pulses, output bit done);
    int n;
    pulses = 0;
    pressed[code] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    for (int i = 0; i < 20; i++) begin
      if (key_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    pressed[code] = 1'b0;
    n = 0;
    while (key_down !== 1'b0 && n < 40) begin
      if (key_valid === 1'b1) pulses++;
      @(negedge clk);
      n++;
    end
    done = (key_down === 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (krow !== 4'b1101) begin n_fail++; $display("FAIL reset_midscan_row: got %b want 1101", krow); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (krow !== 4'b1110) begin n_fail++; $display("FAIL reset_async_row: got %b want 1110", krow); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (hexs !== 16'h0000) begin n_fail++; $display("FAIL reset_hexs: got %h want 0000", hexs); end
    n_checks++;
    if (ndigits !== 3'd0) begin n_fail++; $display("FAIL reset_ndigits: got %0d want 0", ndigits); end
    n_checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0 || key_code !== 4'h0) begin
      n_fail++; $display("FAIL reset_keyflags: got v=%b d=%b c=%h want 0 0 0", key_valid, key_down, key_code);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      n_checks++;
      if (krow !== rows[(i/4)%4]) begin n_fail++; $display("FAIL reset_row_cycle[%0d]: got %b want %b", i, krow, rows[(i/4)%4]); end
      @(negedge clk);
    end
  endtask

  task automatic test_clean_press;
    int pulses;
    pulses = 0;
    pressed[6] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (key_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL clean_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (key_code !== 4'h6) begin n_fail++; $display("FAIL clean_code: got %h want 6", key_code); end
    n_checks++;
    if (hexs !== 16'h0006) begin n_fail++; $display("FAIL clean_hexs: got %h want 0006", hexs); end
    n_checks++;
    if (ndigits !== 3'd1) begin n_fail++; $display("FAIL clean_ndigits: got %0d want 1", ndigits); end
    n_checks++;
    if (key_down !== 1'b1) begin n_fail++; $display("FAIL clean_down_held: got %b want 1", key_down); end
    pressed[6] = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 10) begin
        n_checks++;
        if (key_down !== 1'b1) begin n_fail++; $display("FAIL clean_down_before_fall: got %b want 1", key_down); end
      end
    end
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL clean_down_fall: got %b want 0", key_down); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_bounce;
    bit ok;
    int first, pulses, n;
    bit kd_early, kd_drop;
    first = -1; pulses = 0; kd_early = 0; kd_drop = 0;
    wait_row_start(4'b1011, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bounce_row_wait: got timeout want row 1011"); end
    for (int i = 0; i <= 80; i++) begin
      if (key_valid === 1'b1) begin pulses++; if (first < 0) first = i; end
      if (i < 32 && key_down !== 1'b0) kd_early = 1;
      if (i >= 32 && key_down !== 1'b1) kd_drop = 1;
      pressed[8] = (i < 5) || (i >= 7 && i < 50) || (i >= 54);
      @(negedge clk);
    end
    n_checks++;
    if (first != 32) begin n_fail++; $display("FAIL bounce_accept_time: got %0d want 32", first); end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (key_code !== 4'h8) begin n_fail++; $display("FAIL bounce_code: got %h want 8", key_code); end
    n_checks++;
    if (kd_early || kd_drop) begin n_fail++; $display("FAIL bounce_key_down: got early=%0d drop=%0d want 0 0", kd_early, kd_drop); end
    n_checks++;
    if (hexs !== 16'h0068) begin n_fail++; $display("FAIL bounce_hexs: got %h want 0068", hexs); end
    pressed[8] = 1'b0;
    n = 0;
    while (key_down !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL bounce_release: got %b want 0", key_down); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_digits;
    int pulses;
    bit done;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (hexs !== 16'h0000 || ndigits !== 3'd0) begin n_fail++; $display("FAIL clr_alone: got %h/%0d want 0000/0", hexs, ndigits); end
    for (int k = 1; k <= 5; k++) begin
      press_key(k, pulses, done);
      n_checks++;
      if (pulses != 1 || !done) begin n_fail++; $display("FAIL digit_%0d_press: got pulses=%0d done=%0d want 1 1", k, pulses, done); end
      if (k == 3) begin
        n_checks++;
        if (hexs !== 16'h0123 || ndigits !== 3'd3) begin n_fail++; $display("FAIL digit_3_state: got %h/%0d want 0123/3", hexs, ndigits); end
      end
    end
    n_checks++;
    if (hexs !== 16'h2345) begin n_fail++; $display("FAIL digits_hexs: got %h want 2345", hexs); end
    n_checks++;
    if (ndigits !== 3'd4) begin n_fail++; $display("FAIL digits_saturate: got %0d want 4", ndigits); end
    n_checks++;
    if (key_code !== 4'h5) begin n_fail++; $display("FAIL digits_code: got %h want 5", key_code); end
  endtask

  task automatic test_two_keys;
    int n, extra;
    bit dropped;
    extra = 0; dropped = 0;
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h1) begin n_fail++; $display("FAIL two_keys_code: got v=%b c=%h want 1 1", key_valid, key_code); end
    repeat (10) @(negedge clk);
    pressed[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) extra++;
      if (key_down !== 1'b1) dropped = 1;
    end
    n_checks++;
    if (extra != 0 || dropped) begin n_fail++; $display("FAIL two_keys_other_release: got extra=%0d dropped=%0d want 0 0", extra, dropped); end
    pressed[1] = 1'b0;
    n = 0;
    while (key_down !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL two_keys_release: got %b want 0", key_down); end
    n_checks++;
    if (hexs !== 16'h3451 || ndigits !== 3'd4) begin n_fail++; $display("FAIL two_keys_hexs: got %h/%0d want 3451/4", hexs, ndigits); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clr_with_accept;
    bit ok;
    int n;
    wait_row_start(4'b0111, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL clr_acc_row_wait: got timeout want row 0111"); end
    pressed[14] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 11) begin
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clr_acc_early: got %b want 0", key_valid); end
        clr = 1'b1;
      end
    end
    clr = 1'b0;
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hE) begin n_fail++; $display("FAIL clr_acc_pulse: got v=%b c=%h want 1 e", key_valid, key_code); end
    n_checks++;
    if (hexs !== 16'h000E) begin n_fail++; $display("FAIL clr_acc_hexs: got %h want 000e", hexs); end
    n_checks++;
    if (ndigits !== 3'd1) begin n_fail++; $display("FAIL clr_acc_ndigits: got %0d want 1", ndigits); end
    pressed[14] = 1'b0;
    n = 0;
    while (key_down !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_debounce;
    bit ok;
    int pulses;
    pulses = 0;
    wait_row_start(4'b1011, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_deb_row_wait: got timeout want row 1011"); end
    pressed[9] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (krow !== 4'b1011) begin n_fail++; $display("FAIL rst_deb_frozen_row: got %b want 1011", krow); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (krow !== 4'b1110) begin n_fail++; $display("FAIL rst_deb_row: got %b want 1110", krow); end
    n_checks++;
    if (hexs !== 16'h0000 || ndigits !== 3'd0 || key_code !== 4'h0) begin
      n_fail++; $display("FAIL rst_deb_regs: got %h/%0d/%h want 0000/0/0", hexs, ndigits, key_code);
    end
    n_checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0) begin n_fail++; $display("FAIL rst_deb_flags: got v=%b d=%b want 0 0", key_valid, key_down); end
    pressed[9] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (key_valid === 1'b1) pulses++;
      if (i == 0 || i == 4) begin
        n_checks++;
        if (krow !== rows[i/4]) begin n_fail++; $display("FAIL rst_deb_rescan[%0d]: got %b want %b", i, krow, rows[i/4]); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL rst_deb_no_valid: got %0d want 0", pulses); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    pressed  = 16'h0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_digits();
    test_two_keys();
    test_clr_with_accept();
    test_reset_in_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
